hex_display_ctrl: RTL and testbench

Memory-mapped controller for a bank of seven-segment digits. It is the parametrised successor to the single-digit output port. It sits on the Avalon-MM bus as a zero-wait slave and drives `NUM_DIGITS` seven-segment digits in parallel. It adds per-digit registers, optional hex-font decode, per-digit and global blanking, and a hardware blink timer. Its outputs go directly to the board's HEX pins.

---
 rtl/hex_display_pkg.sv | 41 ++++
 rtl/hex_blink_timer.sv | 64 ++++++
 rtl/hex_display_ctrl.sv | 109 ++++++++++
 tb/tb_hex_display_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared constants, blink-timer state type and hex glyph table for the
// seven-segment display controller.
package hex_display_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'd8;
  localparam logic [3:0] ADDR_BLANK  = 4'd9;
  localparam logic [3:0] ADDR_BLINK  = 4'd10;
  localparam logic [3:0] ADDR_PACKED = 4'd11;
  localparam logic [3:0] ADDR_STATUS = 4'd12;

  localparam int unsigned CTRL_DECODE = 0;
  localparam int unsigned CTRL_BLINK  = 1;
  localparam int unsigned CTRL_GBLANK = 2;

  typedef enum logic [0:0] {StIdle, StRun} blink_state_e;

  // Segment a..g on bits 0..6, active-high.
  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_blink_timer.sv
// Blink half-period timer: counts while enabled and toggles phase on each wrap.
module hex_blink_timer
  import hex_display_pkg::*;
#(
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic phase
);

  localparam int unsigned CntW = $clog2(BLINK_DIV);

  blink_state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    case (state_q)
      StIdle: begin
        cnt_d   = '0;
        phase_d = 1'b0;
        if (enable) state_d = StRun;
      end
      StRun: begin
        // A disable always wins over a coincident wrap.
        if (!enable) begin
          state_d = StIdle;
          cnt_d   = '0;
          phase_d = 1'b0;
        end else if (cnt_q == CntW'(BLINK_DIV - 1)) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        phase_d = 1'b0;
      end
    endcase
  end

  assign phase = phase_q;

endmodule

// File: rtl/hex_display_ctrl.sv
// Avalon-MM seven-segment bank controller: register file, read mux, blanking
// and registered segment outputs.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter int unsigned BLINK_DIV      = 25_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    chipselect,
  input  logic [3:0]              address,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [7*NUM_DIGITS-1:0] hex_out
);

  logic [6:0]              digit_q [NUM_DIGITS];
  logic [6:0]              digit_d [NUM_DIGITS];
  logic [2:0]              ctrl_q, ctrl_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [NUM_DIGITS-1:0]   blink_q, blink_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic                    phase;
  logic                    wr_en;
  logic                    unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_comb begin
    digit_d = digit_q;
    ctrl_d  = ctrl_q;
    blank_d = blank_q;
    blink_d = blink_q;
    if (wr_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (address == 4'(i)) digit_d[i] = writedata[6:0];
      end
      case (address)
        ADDR_CTRL:   ctrl_d  = writedata[2:0];
        ADDR_BLANK:  blank_d = writedata[NUM_DIGITS-1:0];
        ADDR_BLINK:  blink_d = writedata[NUM_DIGITS-1:0];
        ADDR_PACKED: begin
          for (int i = 0; i < NUM_DIGITS; i++) digit_d[i] = {3'b000, writedata[4*i +: 4]};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
      ctrl_q  <= '0;
      blank_q <= '0;
      blink_q <= '0;
      hex_q   <= {(7*NUM_DIGITS){SEG_ACTIVE_LOW}};
    end else begin
      digit_q <= digit_d;
      ctrl_q  <= ctrl_d;
      blank_q <= blank_d;
      blink_q <= blink_d;
      hex_q   <= hex_d;
    end
  end

  // Fed with the next-state enable so that a clear lands on its write edge.
  hex_blink_timer #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (ctrl_d[CTRL_BLINK]),
    .phase  (phase)
  );

  always_comb begin
    hex_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hex_d[7*i +: 7] =
          ((ctrl_q[CTRL_GBLANK] | blank_q[i] | (ctrl_q[CTRL_BLINK] & blink_q[i] & phase))
              ? 7'h00
              : (ctrl_q[CTRL_DECODE] ? hex_font(digit_q[i][3:0]) : digit_q[i]))
          ^ {7{SEG_ACTIVE_LOW}};
    end
  end

  assign hex_out = hex_q;

  always_comb begin
    readdata = '0;
    if (chipselect) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (address == 4'(i)) readdata = {25'b0, digit_q[i]};
      end
      case (address)
        ADDR_CTRL:   readdata[2:0]            = ctrl_q;
        ADDR_BLANK:  readdata[NUM_DIGITS-1:0] = blank_q;
        ADDR_BLINK:  readdata[NUM_DIGITS-1:0] = blink_q;
        ADDR_STATUS: readdata[0]              = phase;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl: directed steps plus random bus
// traffic compared against a cycle-level behavioural model.
module tb_hex_display_ctrl;

  localparam int unsigned ND = 4;
  localparam int unsigned BD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic [3:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [27:0] hex_out;

  always #5 clk = ~clk;

  hex_display_ctrl #(
    .NUM_DIGITS     (ND),
    .SEG_ACTIVE_LOW (1'b1),
    .BLINK_DIV      (BD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .address    (address),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .hex_out    (hex_out)
  );

  int checks   = 0;
  int failures = 0;

  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state
  logic [6:0]  m_digit [ND];
  logic [2:0]  m_ctrl;
  logic [3:0]  m_blank;
  logic [3:0]  m_blink;
  int          m_run;
  bit          m_phase;
  logic [27:0] m_hex;

  function automatic logic [27:0] render();
    logic [27:0] r;
    logic [6:0]  p;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      p = m_ctrl[0] ? font[m_digit[i][3:0]] : m_digit[i];
      if (m_ctrl[2] || m_blank[i] || (m_ctrl[1] && m_blink[i] && m_phase)) p = 7'h00;
      r[7*i +: 7] = ~p;
    end
    return r;
  endfunction

  function automatic logic [31:0] m_read(logic cs, logic [3:0] a);
    if (!cs) return 32'h0;
    if (a < 4) return {25'b0, m_digit[a[1:0]]};
    case (a)
      4'd8:    return {29'b0, m_ctrl};
      4'd9:    return {28'b0, m_blank};
      4'd10:   return {28'b0, m_blink};
      4'd12:   return {31'b0, m_phase};
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ND; i++) m_digit[i] = '0;
    m_ctrl  = '0;
    m_blank = '0;
    m_blink = '0;
    m_run   = 0;
    m_phase = 1'b0;
    m_hex   = 28'hFFFFFFF;
  endtask

  task automatic model_edge(logic cs, logic [3:0] a, logic wn, logic [31:0] wd);
    bit was_on;
    was_on = m_ctrl[1];
    m_hex  = render();
    if (cs && !wn) begin
      if (a < 4) m_digit[a[1:0]] = wd[6:0];
      else begin
        case (a)
          4'd8:  m_ctrl  = wd[2:0];
          4'd9:  m_blank = wd[3:0];
          4'd10: m_blink = wd[3:0];
          4'd11: for (int i = 0; i < ND; i++) m_digit[i] = {3'b000, wd[4*i +: 4]};
          default: ;
        endcase
      end
    end
    // Phase is the parity of completed half-periods since blinking began.
    if (m_ctrl[1] && was_on) m_run++;
    else                     m_run = 0;
    m_phase = m_ctrl[1] && (((m_run / BD) % 2) == 1);
  endtask

  task automatic cycle(logic cs, logic [3:0] a, logic wn, logic [31:0] wd, string tag);
    chipselect = cs;
    address    = a;
    write_n    = wn;
    writedata  = wd;
    #1;
    check({tag, " readdata"}, readdata, m_read(cs, a));
    @(posedge clk);
    model_edge(cs, a, wn, wd);
    #1;
    check({tag, " hex_out"}, {4'b0, hex_out}, {4'b0, m_hex});
  endtask

  task automatic wr(logic [3:0] a, logic [31:0] d);
    cycle(1'b1, a, 1'b0, d, "write");
  endtask

  task automatic rd(logic [3:0] a);
    cycle(1'b1, a, 1'b1, 32'h0, "read");
  endtask

  task automatic idle();
    cycle(1'b0, 4'h0, 1'b1, 32'h0, "idle");
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    check("reset hex_out", {4'b0, hex_out}, {4'b0, m_hex});
    reset = 1'b0;
  endtask

  initial begin
    bit found;
    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = '0;
    writedata  = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    check("reset all off", {4'b0, hex_out}, 32'h0FFFFFFF);
    for (int a = 0; a < 16; a++) rd(4'(a));

    // Decoded packed write
    wr(4'd8, 32'h1);
    wr(4'd11, 32'h0000_3A71);
    idle();
    check("digit0 glyph 1", {25'b0, hex_out[6:0]}, 32'h79);
    check("digit2 glyph A", {25'b0, hex_out[20:14]}, 32'h08);
    chipselect = 1'b1; address = 4'd0; write_n = 1'b1; #1;
    check("DIGIT0 readback", readdata, 32'h1);
    rd(4'd0);

    // Raw pattern and ignored address
    wr(4'd8, 32'h0);
    wr(4'd1, 32'h7F);
    idle();
    check("digit1 raw all lit", {25'b0, hex_out[13:7]}, 32'h0);
    wr(4'd5, 32'hFFFF_FFFF);
    chipselect = 1'b1; address = 4'd5; write_n = 1'b1; #1;
    check("addr5 reads 0", readdata, 32'h0);
    rd(4'd5);

    // Blink digit1
    wr(4'd10, 32'h2);
    wr(4'd8, 32'h3);
    for (int i = 0; i < 4; i++) idle();
    chipselect = 1'b1; address = 4'd12; write_n = 1'b1; #1;
    check("status after 4 cycles", readdata, 32'h1);
    for (int i = 0; i < 8; i++) rd(4'd12);

    // Clear blink_en on a wrap edge while phase is high
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_ctrl[1] && m_phase && ((m_run % BD) == BD - 1)) begin
        found = 1'b1;
        break;
      end
      idle();
    end
    check("wrap cycle reached", {31'b0, found}, 32'h1);
    wr(4'd8, 32'h1);
    chipselect = 1'b1; address = 4'd12; write_n = 1'b1; #1;
    check("phase cleared on wrap", readdata, 32'h0);
    idle();
    check("digit1 lit after clear", {25'b0, hex_out[13:7]}, 32'h0E);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), $urandom, "random");
    end

    // Global blank, then reset mid-blink
    wr(4'd10, 32'hF);
    wr(4'd8, 32'h7);
    for (int i = 0; i < 6; i++) idle();
    check("global blank all off", {4'b0, hex_out}, 32'h0FFFFFFF);
    do_reset();
    check("post reset all off", {4'b0, hex_out}, 32'h0FFFFFFF);
    chipselect = 1'b1; address = 4'd12; write_n = 1'b1; #1;
    check("post reset phase", readdata, 32'h0);
    for (int a = 0; a < 16; a++) rd(4'(a));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
